// File: rtl/srt2_seq_ctrl_if.sv
// Handshake and result bundle for the sequential radix-2 SRT divider.
// Latency: none (wires only).
// Backpressure: none; start is a request that the sequencer samples only while idle.
// Signals: start/Deimpartit/Impartitor come from the requester; busy/done/dbz/Cat/Rest
// (and nz_ops when SRT2_STATS_EN is defined) come back from the sequencer.
interface srt2_seq_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] Deimpartit;
  logic [N-1:0] Impartitor;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [N-1:0] Cat;
  logic [N-1:0] Rest;
`ifdef SRT2_STATS_EN
  logic [3:0]   nz_ops;

  modport master (output start, Deimpartit, Impartitor,
                  input  busy, done, dbz, Cat, Rest, nz_ops);
  modport slave  (input  start, Deimpartit, Impartitor,
                  output busy, done, dbz, Cat, Rest, nz_ops);
`else
  modport master (output start, Deimpartit, Impartitor,
                  input  busy, done, dbz, Cat, Rest);
  modport slave  (input  start, Deimpartit, Impartitor,
                  output busy, done, dbz, Cat, Rest);
`endif
endinterface

// File: rtl/srt2_seq_ctrl.sv
// Sequential radix-2 SRT unsigned divider: normalise, N iterations, correct, denormalise.
// Latency: k+11 edges after the accepting edge (k = leading zeros of divisor); 1 edge for divide-by-zero.
// Backpressure: start is honoured only in IDLE; requests while busy are dropped, never queued.
// Ports: clk, rst (sync, active-low); bus = srt2_seq_ctrl_if.slave carrying start/operands in
// and busy/done/dbz/Cat/Rest out. Optional macro SRT2_STATS_EN adds bus.nz_ops (add/sub count).
module srt2_seq_ctrl #(
  parameter int N  = 8,
  parameter int KW = 3
) (
  input  logic           clk,
  input  logic           rst,
  srt2_seq_ctrl_if.slave bus
);
  // Partial remainder carries one guard bit above its nominal 9 bits: |P| stays below y
  // (up to 255), so 2P+1 can reach +/-510 and would wrap in 9 bits.
  localparam int PW = N + 2;

  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ITER, S_CORR, S_DENORM, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_p;
  logic [N-1:0]  r_x, r_y, r_cat, r_rest;
  logic [KW-1:0] r_k, r_it;
  logic          r_dbz;
  logic          w_busy, w_done;
  logic [PW-1:0] w_p_sh, w_y_ext, w_p_iter;
  logic [N-1:0]  w_x_sh, w_x_iter;
  logic          w_sub, w_add;
`ifdef SRT2_STATS_EN
  logic [3:0]    r_ops, r_nz_ops;
`endif

  // One SRT step: shift {P,x} left, then choose digit from the top of P.
  always_comb begin
    w_p_sh  = {r_p[PW-2:0], r_x[N-1]};
    w_x_sh  = {r_x[N-2:0], 1'b0};
    w_y_ext = {2'b00, r_y};
    // P >= 2^(N-2): digit +1.  P < -2^(N-2): digit -1.  Otherwise digit 0.
    w_sub    = !w_p_sh[PW-1] && (w_p_sh[PW-2:N-2] != '0);
    w_add    =  w_p_sh[PW-1] && (w_p_sh[PW-2:N-2] != '1);
    w_p_iter = w_p_sh;
    w_x_iter = w_x_sh;
    if (w_sub) begin
      w_p_iter = w_p_sh - w_y_ext;
      w_x_iter = w_x_sh + N'(1);
    end else if (w_add) begin
      w_p_iter = w_p_sh + w_y_ext;
      w_x_iter = w_x_sh - N'(1);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_state_nxt = (bus.Impartitor != '0) ? S_NORM : S_DONE;
      S_NORM:   if (r_y[N-1]) w_state_nxt = S_ITER;
      S_ITER:   if (r_it == KW'(N-1)) w_state_nxt = S_CORR;
      S_CORR:   w_state_nxt = S_DENORM;
      S_DENORM: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Control outputs
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_done = (r_state == S_DONE);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_p    <= '0;
      r_x    <= '0;
      r_y    <= '0;
      r_k    <= '0;
      r_it   <= '0;
      r_cat  <= '0;
      r_rest <= '0;
      r_dbz  <= 1'b0;
`ifdef SRT2_STATS_EN
      r_ops    <= '0;
      r_nz_ops <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          if (bus.Impartitor != '0) begin
            r_x <= bus.Deimpartit;
            r_y <= bus.Impartitor;
            r_p <= '0;
            r_k <= '0;
`ifdef SRT2_STATS_EN
            r_ops <= '0;
`endif
          end else begin
            r_cat  <= '1;
            r_rest <= bus.Deimpartit;
            r_dbz  <= 1'b1;
`ifdef SRT2_STATS_EN
            r_nz_ops <= '0;
`endif
          end
        end
        S_NORM: begin
          if (r_y[N-1]) begin
            r_it <= '0;
          end else begin
            {r_p, r_x} <= {r_p[PW-2:0], r_x, 1'b0};
            r_y        <= {r_y[N-2:0], 1'b0};
            r_k        <= r_k + KW'(1);
          end
        end
        S_ITER: begin
          r_p  <= w_p_iter;
          r_x  <= w_x_iter;
          r_it <= r_it + KW'(1);
`ifdef SRT2_STATS_EN
          if (w_sub || w_add) r_ops <= r_ops + 4'd1;
`endif
        end
        S_CORR: if (r_p[PW-1]) begin
          // Negative remainder: restore and take one back from the quotient.
          r_p <= r_p + w_y_ext;
          r_x <= r_x - N'(1);
`ifdef SRT2_STATS_EN
          r_ops <= r_ops + 4'd1;
`endif
        end
        S_DENORM: begin
          r_cat  <= r_x;
          r_rest <= r_p[N-1:0] >> r_k;
          r_dbz  <= 1'b0;
`ifdef SRT2_STATS_EN
          r_nz_ops <= r_ops;
`endif
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.dbz  = r_dbz;
  assign bus.Cat  = r_cat;
  assign bus.Rest = r_rest;
`ifdef SRT2_STATS_EN
  assign bus.nz_ops = r_nz_ops;
`endif
endmodule

// File: tb/tb_srt2_seq_ctrl.sv
// Bench for srt2_seq_ctrl: directed cases with literal expectations plus randomized
// operations, all checked every cycle against a behavioural divide model.
module tb_srt2_seq_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  srt2_seq_ctrl_if #(.N(8)) bus ();

  srt2_seq_ctrl #(.N(8), .KW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int clz(input logic [7:0] v);
    int n;
    n = 0;
    for (int b = 7; b >= 0; b--) begin
      if (v[b]) break;
      n++;
    end
    return n;
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks only "idle / counting down to done / done" and the arithmetic result.
  bit         m_valid = 0;
  bit         m_idle  = 1;
  bit         m_done  = 0;
  bit         m_dbz   = 0;
  bit         m_nzclr = 0;
  int         m_left  = 0;
  logic [7:0] m_cat = '0, m_rest = '0, p_cat = '0, p_rest = '0;

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      m_valid = 1; m_idle = 1; m_done = 0; m_left = 0;
      m_cat = 8'd0; m_rest = 8'd0; m_dbz = 0; m_nzclr = 1;
    end else if (m_valid) begin
      if (m_done) begin
        m_done = 0;
        m_idle = 1;
      end else if (m_idle) begin
        if (bus.start) begin
          m_idle = 0;
          if (bus.Impartitor == 8'd0) begin
            m_done = 1; m_cat = 8'hFF; m_rest = bus.Deimpartit; m_dbz = 1;
          end else begin
            m_left = clz(bus.Impartitor) + 11;
            p_cat  = bus.Deimpartit / bus.Impartitor;
            p_rest = bus.Deimpartit % bus.Impartitor;
          end
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done = 1; m_cat = p_cat; m_rest = p_rest; m_dbz = 0; m_nzclr = 0;
        end
      end
    end
  end

  // Compare process: outputs are sampled mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("busy", bus.busy, !m_idle);
      chk("done", bus.done, m_done);
      chk("dbz",  bus.dbz,  m_dbz);
      chk("Cat",  bus.Cat,  m_cat);
      chk("Rest", bus.Rest, m_rest);
`ifdef SRT2_STATS_EN
      if (m_nzclr) chk("nz_ops_clear", bus.nz_ops, 0);
      if (m_done && m_dbz)  chk("nz_ops_dbz", bus.nz_ops, 0);
      if (m_done && !m_dbz) chk("nz_ops_le9", (bus.nz_ops <= 4'd9), 1);
`endif
    end
  end

  // Issue one operation and wait for done. lat = edges after the accepting edge.
  // With lit set, the result is also checked against hand-computed values.
  task automatic run_op(input logic [7:0] d, input logic [7:0] i, input bit lit,
                        input int e_lat, input int e_cat, input int e_rest,
                        input int e_dbz, input string nm);
    int lat;
    bit seen;
    lat  = -1;
    seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.Deimpartit = d; bus.Impartitor = i;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        seen = 1; lat = c; bus.start = 1'b0;
      end else begin
        // Operands (and stray starts in random mode) must have no effect while busy.
        bus.start      = lit ? 1'b0 : ($urandom_range(0, 3) == 0);
        bus.Deimpartit = 8'($urandom);
        bus.Impartitor = 8'($urandom);
      end
    end
    bus.start = 1'b0;
    if (!seen) chk({nm, "_timeout"}, 0, 1);
    else if (lit) begin
      chk({nm, "_lat"},  lat,      e_lat);
      chk({nm, "_cat"},  bus.Cat,  e_cat);
      chk({nm, "_rest"}, bus.Rest, e_rest);
      chk({nm, "_dbz"},  bus.dbz,  e_dbz);
    end
  endtask

  initial begin
    int lat1, lat2, dcount;
    logic [7:0] d, i;
    int sel;
    rst = 1'b0;
    bus.start = 1'b0; bus.Deimpartit = '0; bus.Impartitor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cat",  bus.Cat,  0);
    chk("rst_rest", bus.Rest, 0);
    rst = 1'b1;

    run_op(8'd127, 8'd25,  1, 14, 5,   2,   0, "d127_25");
    run_op(8'd200, 8'd200, 1, 11, 1,   0,   0, "d200_200");
    run_op(8'd255, 8'd1,   1, 18, 255, 0,   0, "d255_1");
    run_op(8'd77,  8'd0,   1, 0,  255, 77,  1, "d77_0");
    run_op(8'd10,  8'd3,   1, 17, 3,   1,   0, "d10_3");
    run_op(8'd128, 8'd255, 1, 11, 0,   128, 0, "d128_255");
    run_op(8'd254, 8'd255, 1, 11, 0,   254, 0, "d254_255");

    // Reset in the middle of 100/7: the 5th edge counting the accepting one sees rst low.
    @(negedge clk);
    bus.start = 1'b1; bus.Deimpartit = 8'd100; bus.Impartitor = 8'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cat",  bus.Cat,  0);
    chk("mid_rst_rest", bus.Rest, 0);
    rst = 1'b1;
    dcount = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcount++;
    end
    chk("mid_rst_no_done", dcount, 0);
    run_op(8'd100, 8'd7, 1, 16, 14, 2, 0, "d100_7");

    // start held high: 50/6, operands switch to 9/9 during ITER, second op follows at once.
    @(negedge clk);
    bus.start = 1'b1; bus.Deimpartit = 8'd50; bus.Impartitor = 8'd6;
    lat1 = -1;
    for (int c = 0; c < 40 && lat1 < 0; c++) begin
      @(negedge clk);
      if (c == 6) begin bus.Deimpartit = 8'd9; bus.Impartitor = 8'd9; end
      if (bus.done === 1'b1) lat1 = c;
    end
    chk("b2b_first_lat", lat1, 16);
    chk("b2b_first_cat", bus.Cat, 8);
    chk("b2b_first_rest", bus.Rest, 2);
    lat2 = -1;
    for (int c = 0; c < 40 && lat2 < 0; c++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin lat2 = c + 1; bus.start = 1'b0; end
    end
    bus.start = 1'b0;
    chk("b2b_gap", lat2, 17);
    chk("b2b_second_cat", bus.Cat, 1);
    chk("b2b_second_rest", bus.Rest, 0);

    // Randomized operations, biased towards edge operands.
    for (int t = 0; t < 1500; t++) begin
      sel = $urandom_range(0, 9);
      d   = 8'($urandom);
      i   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : (sel == 2) ? 8'd128 :
            (sel == 3) ? 8'd1 : 8'($urandom_range(1, 255));
      if ($urandom_range(0, 9) == 0) d = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
      run_op(d, i, 0, 0, 0, 0, 0, "rand");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
